// File: rtl/clock_pkg.sv
// Shared definitions for the alarm sequencer: state encoding, BCD limits,
// default ring/snooze durations and the alarm-time record.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_ARMED    = 3'd3,
    ST_RINGING  = 3'd4,
    ST_SNOOZE   = 3'd5
  } alarm_state_t;

  localparam int HOUR_MAX           = 23;
  localparam int MIN_MAX            = 59;
  localparam int RING_SEC_DEFAULT   = 60;
  localparam int SNOOZE_SEC_DEFAULT = 300;

  // Alarm time as BCD digit fields, widths matching the display digits.
  typedef struct packed {
    logic [1:0] tens_hour;
    logic [3:0] units_hour;
    logic [2:0] tens_min;
    logic [3:0] units_min;
  } alarm_time_t;

  localparam alarm_time_t ALARM_RESET = '{
    tens_hour:  2'd0,
    units_hour: 4'd7,
    tens_min:   3'd0,
    units_min:  4'd0
  };

  // Display/indicator flags that depend only on the FSM state.
  typedef struct packed {
    logic       show;    // display mux selects alarm digits
    logic [1:0] digits;  // blink request {minute pair, hour pair}
    logic       armed;   // armed dot
  } ui_flags_t;

  function automatic ui_flags_t flags_of(input alarm_state_t s);
    ui_flags_t f;
    f = '0;
    case (s)
      ST_SET_HOUR: begin f.show = 1'b1; f.digits = 2'b01; end
      ST_SET_MIN:  begin f.show = 1'b1; f.digits = 2'b10; end
      ST_ARMED, ST_RINGING, ST_SNOOZE: f.armed = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bcd_field_inc.sv
// Combinational two-digit BCD increment that wraps to 00 past LIMIT.
module bcd_field_inc
  import clock_pkg::*;
#(
  parameter int TENS_W = 3,
  parameter int LIMIT  = MIN_MAX
) (
  input  logic [TENS_W-1:0] tens,
  input  logic [3:0]        units,
  output logic [TENS_W-1:0] tens_next,
  output logic [3:0]        units_next
);

  localparam logic [TENS_W-1:0] LIM_TENS  = TENS_W'(LIMIT / 10);
  localparam logic [3:0]        LIM_UNITS = 4'(LIMIT % 10);

  // Wrap at the limit, carry a units 9 into tens, otherwise bump units.
  always_comb begin
    tens_next  = tens;
    units_next = units + 4'd1;
    if (tens == LIM_TENS && units == LIM_UNITS) begin
      tens_next  = '0;
      units_next = '0;
    end else if (units == 4'd9) begin
      tens_next  = tens + 1'b1;
      units_next = '0;
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm sequencer: holds the BCD alarm time, runs the set/arm/ring/snooze
// state machine and drives the display mux, blink request, armed dot and
// buzzer. RING_SEC and SNOOZE_SEC must both be at least 1.
module alarm_controller
  import clock_pkg::*;
#(
  parameter int RING_SEC   = RING_SEC_DEFAULT,
  parameter int SNOOZE_SEC = SNOOZE_SEC_DEFAULT
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Enable_1Hz,
  input  logic       i_Tone,
  input  logic       i_Button_Alarm,
  input  logic       i_Button_Up,
  input  logic       i_Time_Mode,
  input  logic [3:0] i_Units_Sec,
  input  logic [2:0] i_Tens_Sec,
  input  logic [3:0] i_Units_Min,
  input  logic [2:0] i_Tens_Min,
  input  logic [3:0] i_Units_Hour,
  input  logic [1:0] i_Tens_Hour,
  output logic       o_Show_Alarm,
  output logic [3:0] o_Alarm_Units_Min,
  output logic [2:0] o_Alarm_Tens_Min,
  output logic [3:0] o_Alarm_Units_Hour,
  output logic [1:0] o_Alarm_Tens_Hour,
  output logic [1:0] o_Display_Enable_Digits,
  output logic       o_Armed,
  output logic       o_Buzzer
);

  localparam int CNT_W = $clog2(max_int(RING_SEC, SNOOZE_SEC) + 1);
  localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SEC);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SEC);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  alarm_state_t     state;
  ui_flags_t        flags;
  alarm_time_t      alarm_q;
  logic [CNT_W-1:0] sec_cnt;
  logic             match;
  logic             match_d;
  logic             buzzer;

  logic [1:0] hour_tens_nx;
  logic [3:0] hour_units_nx;
  logic [2:0] min_tens_nx;
  logic [3:0] min_units_nx;

  bcd_field_inc #(.TENS_W(2), .LIMIT(HOUR_MAX)) u_hour_inc (
    .tens       (alarm_q.tens_hour),
    .units      (alarm_q.units_hour),
    .tens_next  (hour_tens_nx),
    .units_next (hour_units_nx)
  );

  // Minutes wrap on their own; there is no carry into the hour field.
  bcd_field_inc #(.TENS_W(3), .LIMIT(MIN_MAX)) u_min_inc (
    .tens       (alarm_q.tens_min),
    .units      (alarm_q.units_min),
    .tens_next  (min_tens_nx),
    .units_next (min_units_nx)
  );

  // Alarm time reached exactly at the top of the minute.
  assign match = (i_Tens_Hour  == alarm_q.tens_hour)  &&
                 (i_Units_Hour == alarm_q.units_hour) &&
                 (i_Tens_Min   == alarm_q.tens_min)   &&
                 (i_Units_Min  == alarm_q.units_min)  &&
                 (i_Tens_Sec   == 3'd0) && (i_Units_Sec == 4'd0);

  // Sequencer: state, registered UI flags, alarm digits, second counter,
  // match history and buzzer. Button checks precede the 1 Hz expiry so a
  // coinciding button press always wins; Alarm is tested before Up.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state   <= ST_OFF;
      flags   <= '0;
      alarm_q <= ALARM_RESET;
      sec_cnt <= '0;
      match_d <= 1'b0;
      buzzer  <= 1'b0;
    end else begin
      match_d <= match;
      buzzer  <= (state == ST_RINGING) & i_Tone;
      case (state)
        ST_OFF: begin
          if (i_Button_Alarm && !i_Time_Mode) begin
            state <= ST_SET_HOUR;
            flags <= flags_of(ST_SET_HOUR);
          end
        end
        ST_SET_HOUR: begin
          // Entering time-set abandons editing but keeps what was edited.
          if (i_Time_Mode) begin
            state <= ST_OFF;
            flags <= flags_of(ST_OFF);
          end else if (i_Button_Alarm) begin
            state <= ST_SET_MIN;
            flags <= flags_of(ST_SET_MIN);
          end else if (i_Button_Up) begin
            alarm_q.tens_hour  <= hour_tens_nx;
            alarm_q.units_hour <= hour_units_nx;
          end
        end
        ST_SET_MIN: begin
          if (i_Time_Mode) begin
            state <= ST_OFF;
            flags <= flags_of(ST_OFF);
          end else if (i_Button_Alarm) begin
            state <= ST_ARMED;
            flags <= flags_of(ST_ARMED);
          end else if (i_Button_Up) begin
            alarm_q.tens_min  <= min_tens_nx;
            alarm_q.units_min <= min_units_nx;
          end
        end
        ST_ARMED: begin
          // Only a rising match rings, so arming inside the matching
          // second stays quiet for that minute.
          if (i_Button_Alarm && !i_Time_Mode) begin
            state <= ST_OFF;
            flags <= flags_of(ST_OFF);
          end else if (match && !match_d) begin
            state   <= ST_RINGING;
            flags   <= flags_of(ST_RINGING);
            sec_cnt <= RING_LOAD;
          end
        end
        ST_RINGING: begin
          if (i_Button_Alarm) begin
            state   <= ST_ARMED;
            flags   <= flags_of(ST_ARMED);
            sec_cnt <= '0;
          end else if (i_Button_Up) begin
            state   <= ST_SNOOZE;
            flags   <= flags_of(ST_SNOOZE);
            sec_cnt <= SNOOZE_LOAD;
          end else if (i_Enable_1Hz) begin
            if (sec_cnt == CNT_ONE) begin
              state   <= ST_ARMED;
              flags   <= flags_of(ST_ARMED);
              sec_cnt <= '0;
            end else begin
              sec_cnt <= sec_cnt - 1'b1;
            end
          end
        end
        ST_SNOOZE: begin
          if (i_Button_Alarm) begin
            state   <= ST_ARMED;
            flags   <= flags_of(ST_ARMED);
            sec_cnt <= '0;
          end else if (i_Enable_1Hz) begin
            if (sec_cnt == CNT_ONE) begin
              state   <= ST_RINGING;
              flags   <= flags_of(ST_RINGING);
              sec_cnt <= RING_LOAD;
            end else begin
              sec_cnt <= sec_cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= ST_OFF;
          flags <= flags_of(ST_OFF);
        end
      endcase
    end
  end

  assign o_Show_Alarm            = flags.show;
  assign o_Display_Enable_Digits = flags.digits;
  assign o_Armed                 = flags.armed;
  assign o_Buzzer                = buzzer;
  assign o_Alarm_Tens_Hour       = alarm_q.tens_hour;
  assign o_Alarm_Units_Hour      = alarm_q.units_hour;
  assign o_Alarm_Tens_Min        = alarm_q.tens_min;
  assign o_Alarm_Units_Min       = alarm_q.units_min;

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Alarm sequencer for the FPGA clock. Holds the alarm time (BCD HH:MM) and runs the state machine for alarm setting, arming, ringing, snooze and dismissal. It decides when the display shows alarm digits instead of current time, and drives the buzzer. It sits beside the control unit and clock counters, on the 32768 Hz main clock, and consumes the debounced button pulses and the 1 Hz enable.

## Interface
- RING_SEC, 60: seconds the buzzer rings before auto-dismiss; must be ≥ 1.
- SNOOZE_SEC, 300: seconds of snooze before re-ringing; must be ≥ 1.
- i_Clock  in  1  main clock, 32768 Hz.
- i_Reset  in  1  reset; one clock, asynchronous, active-high.
- i_Enable_1Hz  in  1  one-cycle pulse per second.
- i_Tone  in  1  buzzer tone square wave, 1024 Hz.
- i_Button_Alarm  in  1  one-cycle released pulse, alarm button.
- i_Button_Up  in  1  one-cycle released pulse, up button.
- i_Time_Mode  in  1  high while the control unit is setting the time.
- i_Units_Sec, i_Tens_Sec, i_Units_Min, i_Tens_Min, i_Units_Hour, i_Tens_Hour  in  4/3/4/3/4/2  current time, BCD.
- o_Show_Alarm  out  1  display mux selects alarm digits.
- o_Alarm_Units_Min, o_Alarm_Tens_Min, o_Alarm_Units_Hour, o_Alarm_Tens_Hour  out  4/3/4/2  alarm time, BCD.
- o_Display_Enable_Digits  out  2  blink request: bit0 = hour pair, bit1 = minute pair.
- o_Armed  out  1  alarm armed indicator (dot).
- o_Buzzer  out  1  buzzer drive.

## Operation
- States: OFF, SET_HOUR, SET_MIN, ARMED, RINGING, SNOOZE.
- Alarm button transitions:
  - OFF → SET_HOUR → SET_MIN → ARMED → OFF.
  - RINGING → ARMED (dismiss).
  - SNOOZE → ARMED (cancel snooze).
- Up button:
  - SET_HOUR: hours +1, BCD, 23 → 00.
  - SET_MIN: minutes +1, 59 → 00; no carry into hours.
  - RINGING → SNOOZE.
  - Ignored in all other states.
- Alarm and Up pulses in the same cycle: Alarm wins; no increment, no snooze.
- Time-mode interaction:
  - i_Time_Mode high in OFF or ARMED: alarm button ignored.
  - i_Time_Mode high in SET_HOUR or SET_MIN: go to OFF; edited values are kept.
  - RINGING and SNOOZE are unaffected by i_Time_Mode.
- Match:
  - match = current HH:MM equals alarm HH:MM, and seconds are 00.
  - match_d is the match registered every cycle, in every state.
  - Trigger when match & ~match_d while in ARMED: go to RINGING.
  - Entering ARMED while match is already high does not ring in that minute.
- Second counter:
  - Loaded with RING_SEC on entry to RINGING, and with SNOOZE_SEC on entry to SNOOZE.
  - Decrements on i_Enable_1Hz.
  - A pulse while the counter is 1 ends the phase: RINGING → ARMED, SNOOZE → RINGING (reload RING_SEC).
  - Width is clog2(max(RING_SEC, SNOOZE_SEC) + 1).
- Outputs:
  - o_Show_Alarm = SET_HOUR | SET_MIN.
  - o_Display_Enable_Digits = {SET_MIN, SET_HOUR}.
  - o_Armed = ARMED | RINGING | SNOOZE.
  - o_Buzzer = RINGING & i_Tone.

## Timing
- Reset values:
  - State OFF.
  - Alarm 07:00 (tens hour 0, units hour 7, minutes 0).
  - Counter 0, match_d 0.
  - All outputs 0, except alarm digits, which read 07:00.
- State changes take effect the cycle after the triggering pulse.
- Alarm digit updates take effect the cycle after the Up pulse.
- All outputs are registered or decoded from registered state.
- o_Buzzer is registered: it reflects RINGING & i_Tone of the previous cycle.
- Ring starts on the clock edge after the seconds counters show 00, i.e. one cycle after the match rise.
- Reset asserted mid-ring or mid-snooze: immediate return to reset values; buzzer off asynchronously.
- A button pulse coinciding with the ring/snooze expiry pulse: the button wins.

## Structure
- Shared package clock_pkg holds:
  - the state encoding constants (3 bits);
  - BCD limits (HOUR_MAX 23, MIN_MAX 59);
  - default RING_SEC and SNOOZE_SEC.
- Sub-module bcd_field_inc: combinational BCD increment with a wrap limit, instantiated twice (hours, minutes).
- The FSM, second counter and match logic live in alarm_controller.

## Test plan
- Reset, then three Alarm pulses:
  - states SET_HOUR, SET_MIN, ARMED in turn;
  - o_Show_Alarm high for two states;
  - o_Display_Enable_Digits 01 then 10;
  - o_Armed 1 at the end.
- In SET_HOUR, 17 Up pulses from 07 → hours 00 (wrap at 23).
- In SET_MIN, 60 Up pulses from 00 → 00 with hours unchanged; Alarm and Up in the same cycle → state advances, minutes unchanged.
- Armed at 07:00, time steps 06:59:59 → 07:00:00:
  - RINGING the next cycle;
  - o_Buzzer follows i_Tone;
  - after RING_SEC=3 1 Hz pulses → ARMED, buzzer 0.
- RINGING, then Up → SNOOZE, buzzer 0; after SNOOZE_SEC=2 pulses → RINGING; then Alarm → ARMED.
- Async reset mid-RINGING → o_Buzzer 0 before the next clock edge; alarm reads 07:00.
- Arm while the time already reads 07:00:00 → no ring; i_Time_Mode rising in SET_MIN → OFF with edited minutes kept.
